// File: rtl/wdt_pkg.sv
// Shared watchdog definitions: register offsets, default kick value and the
// kicker FSM state encoding.
package wdt_pkg;

  localparam logic [4:0] R_CTRL = 5'd0;
  localparam logic [4:0] R_TOUT = 5'd1;
  localparam logic [4:0] R_KICK = 5'd2;
  localparam logic [4:0] R_CNT  = 5'd3;

  localparam logic [7:0] KICK_DEFAULT = 8'h6b;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2,
    REL   = 2'd3
  } kick_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/hb_sync.sv
// Heartbeat synchronizer (two flops) followed by an any-edge detector.
// Only built when WDT_KICKER_HEARTBEAT_EN is defined.
`ifdef WDT_KICKER_HEARTBEAT_EN
module hb_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic s1, s2, s3;

  // shift the async input through the synchronizer and one history flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 ^ s3;

endmodule
`endif

// File: rtl/wdt_kicker.sv
// Periodic watchdog kicker: a CSR bus master that writes KICK_VALUE to the
// watchdog kick register once per window. WDT_KICKER_HEARTBEAT_EN gates kicks on SoC heartbeat.
module wdt_kicker
  import wdt_pkg::*;
#(
  parameter logic [4:0] WDT_BASE_ADDR = 5'h0,
  parameter logic [7:0] KICK_VALUE    = KICK_DEFAULT,
  parameter logic [7:0] PERIOD        = 8'd64,
  parameter logic [2:0] MISS_LIMIT    = 3'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       en,
  input  logic       heartbeat,
  output logic       bus_req,
  input  logic       bus_gnt,
  output logic [4:0] csr_a,
  output logic [7:0] csr_do,
  output logic       csr_we,
  output logic       stalled,
  output logic [7:0] kick_cnt
);

  localparam logic [7:0] RELOAD = PERIOD - 8'd1;

  kick_state_e state, state_nx;
  logic [7:0]  win_cnt;
  logic        window_end;
  logic        kick_pending;
  logic        kick_set;

  // window counter and one-cycle window_end strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt    <= RELOAD;
      window_end <= 1'b0;
    end else if (!en) begin
      win_cnt    <= RELOAD;
      window_end <= 1'b0;
    end else if (ce && (win_cnt == 8'd0)) begin
      win_cnt    <= RELOAD;
      window_end <= 1'b1;
    end else begin
      if (ce) win_cnt <= win_cnt - 8'd1;
      window_end <= 1'b0;
    end
  end

`ifdef WDT_KICKER_HEARTBEAT_EN
  logic       hb_edge;
  logic       hb_seen;
  logic [2:0] miss_cnt;

  hb_sync u_hb_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (heartbeat),
    .pulse (hb_edge)
  );

  // miss tracking: a heartbeat edge always wins over a stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_seen  <= 1'b0;
      miss_cnt <= 3'd0;
      stalled  <= 1'b0;
    end else begin
      if (hb_edge && stalled) begin
        stalled  <= 1'b0;
        miss_cnt <= 3'd0;
      end else if (window_end && !stalled) begin
        if (hb_seen) begin
          miss_cnt <= 3'd0;
        end else begin
          miss_cnt <= miss_cnt + 3'd1;
          if ((miss_cnt + 3'd1) == MISS_LIMIT) stalled <= 1'b1;
        end
      end
      if (!en)             hb_seen <= 1'b0;
      else if (hb_edge)    hb_seen <= 1'b1;
      else if (window_end) hb_seen <= 1'b0;
    end
  end

  assign kick_set = window_end && hb_seen && !stalled;
`else
  logic unused_hb;
  assign unused_hb = heartbeat;
  assign stalled   = 1'b0;
  assign kick_set  = window_end;
`endif

  // pending kick; repeated window ends merge into one request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kick_pending <= 1'b0;
    end else if ((state == REQ) && !en) begin
      kick_pending <= 1'b0;
    end else if (kick_set) begin
      kick_pending <= 1'b1;
    end else if (state == WRITE) begin
      kick_pending <= 1'b0;
    end
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (kick_pending && en) state_nx = REQ; else state_nx = IDLE;
      REQ: begin
        if (!en)          state_nx = IDLE;
        else if (bus_gnt) state_nx = WRITE;
        else              state_nx = REQ;
      end
      WRITE:   state_nx = REL;
      REL:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state register; outputs are registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bus_req  <= 1'b0;
      csr_we   <= 1'b0;
      csr_a    <= 5'h00;
      csr_do   <= 8'h00;
      kick_cnt <= 8'h00;
    end else begin
      state   <= state_nx;
      bus_req <= (state_nx == REQ) || (state_nx == WRITE);
      csr_we  <= (state_nx == WRITE);
      csr_a   <= (state_nx == WRITE) ? (WDT_BASE_ADDR + R_KICK) : 5'h00;
      csr_do  <= (state_nx == WRITE) ? KICK_VALUE : 8'h00;
      if (state_nx == REL) kick_cnt <= sat_inc8(kick_cnt);
    end
  end

endmodule

// File: doc/wdt_kicker.md
WDT_KICKER -- requirements
Module: wdt_kicker

Interface
REQ-001 SHALL have parameter WDT_BASE_ADDR, default 5'h0, meaning the watchdog CSR base address targeted by kicks.
REQ-002 SHALL have parameter KICK_VALUE, default 8'h6b, meaning the data byte written to the watchdog kick register.
REQ-003 SHALL have parameter PERIOD, default 8'd64, meaning the number of ce ticks per kick window (legal range 1..255).
REQ-004 SHALL have parameter MISS_LIMIT, default 3'd3, meaning the number of consecutive heartbeat-less windows before stalling (legal range 1..7).
REQ-005 SHALL have port clk, input, width 1, meaning the single system clock; all state is on its rising edge.
REQ-006 SHALL have port rst, input, width 1, meaning the reset; it is asynchronous and active-high.
REQ-007 SHALL have port ce, input, width 1, meaning the one-cycle tick strobe that advances the window counter.
REQ-008 SHALL have port en, input, width 1, meaning kicking is enabled.
REQ-009 SHALL have port heartbeat, input, width 1, meaning an asynchronous liveness signal from the SoC, where any edge counts.
REQ-010 SHALL have port bus_req, output, width 1, meaning a request for CSR bus ownership.
REQ-011 SHALL have port bus_gnt, input, width 1, meaning the arbiter grant.
REQ-012 SHALL have ports csr_a (output, 5 bits), csr_do (output, 8 bits) and csr_we (output, 1 bit), meaning the CSR master write port.
REQ-013 SHALL have port stalled, output, width 1, meaning the miss limit has been reached and kicking is suspended.
REQ-014 SHALL have port kick_cnt, output, width 8, meaning a saturating count of completed kicks.

Function
REQ-015 The window counter SHALL load PERIOD-1, decrement on ce while en=1, and on ce at 0 SHALL reload PERIOD-1 and raise window_end for one cycle.
REQ-016 While en=0, the window counter SHALL hold at PERIOD-1 and the heartbeat-seen flag SHALL be cleared.
REQ-017 Heartbeat SHALL pass a 2-flop synchronizer and edge detector, so an edge sets hb_seen within 3 clk cycles.
REQ-018 At window_end with hb_seen=1, the block SHALL set kick_pending, clear hb_seen and clear miss_cnt.
REQ-019 At window_end with hb_seen=0, the block SHALL leave kick_pending unchanged and increment miss_cnt; stalled SHALL assert when miss_cnt reaches MISS_LIMIT.
REQ-020 While stalled=1, no new kick_pending SHALL be set; the next heartbeat edge SHALL clear stalled and miss_cnt in the same cycle and set hb_seen.
REQ-021 A window_end while kick_pending=1 SHALL merge into the existing pending kick, with no queueing.
REQ-022 The FSM SHALL have states IDLE, REQ, WRITE and REL.
REQ-023 In IDLE, the FSM SHALL go to REQ when kick_pending=1 and en=1.
REQ-024 In REQ, bus_req SHALL be 1; bus_gnt=1 SHALL move the FSM to WRITE, and en=0 SHALL return it to IDLE with kick_pending cleared.
REQ-025 In WRITE, for exactly one cycle, csr_we SHALL be 1, csr_a SHALL be WDT_BASE_ADDR+5'h2 and csr_do SHALL be KICK_VALUE; bus_req SHALL stay 1 and kick_pending SHALL clear.
REQ-026 WRITE SHALL complete even if en or bus_gnt drops during it.
REQ-027 In REL, bus_req SHALL be 0 and kick_cnt SHALL increment, saturating at 8'hff; the FSM SHALL then go to IDLE.
REQ-028 All outputs SHALL be registered; the write SHALL occur on the cycle after bus_gnt is sampled high in REQ.
REQ-029 csr_a, csr_do and csr_we SHALL be 0 outside WRITE.

Reset
REQ-030 Asserting rst SHALL immediately set the FSM to IDLE and bus_req, csr_we, csr_a, csr_do, stalled, kick_cnt, miss_cnt, hb_seen and kick_pending to 0, with the window counter at PERIOD-1.
REQ-031 rst asserted during WRITE SHALL abort the write asynchronously, with no partial cycle on csr_we after release.

Configuration
REQ-032 Macro WDT_KICKER_HEARTBEAT_EN defined SHALL give the heartbeat-gated behaviour of REQ-017..REQ-020.
REQ-033 Without WDT_KICKER_HEARTBEAT_EN, every window_end SHALL set kick_pending, the synchronizer SHALL be omitted, heartbeat SHALL be ignored, and stalled SHALL be tied to 0.

Structure
REQ-034 Package wdt_pkg SHALL hold the watchdog register offsets (R_CTRL=0, R_TOUT=1, R_KICK=2, R_CNT=3), the default kick value 8'h6b and the kicker FSM state enum.
REQ-035 One sub-module, hb_sync (synchronizer plus any-edge detector), SHALL exist; it SHALL be instantiated only when WDT_KICKER_HEARTBEAT_EN is defined.

Verification
REQ-036 With PERIOD=4, ce every cycle, en=1, macro off and bus_gnt tied 1, the bench SHALL see a csr_we pulse with a=5'h2 and do=8'h6b every 4 cycles, and kick_cnt SHALL reach 3 after 3 windows.
REQ-037 With the macro on, no heartbeat and MISS_LIMIT=3, stalled SHALL assert at the 3rd window_end with zero writes; one heartbeat toggle SHALL clear stalled within 3 cycles, and a kick SHALL follow the next window_end.
REQ-038 Holding bus_gnt=0 for 10 windows SHALL keep bus_req=1 with a single write upon grant, and kick_cnt SHALL increment by exactly 1.
REQ-039 en dropped in REQ SHALL bring bus_req to 0 the next cycle with no write; en dropped in WRITE SHALL still complete the write.
REQ-040 rst pulsed mid-WRITE SHALL bring csr_we and bus_req to 0 immediately, with kick_cnt=0 and the next write occurring PERIOD ticks after release.
REQ-041 Forcing kick_cnt to 8'hff followed by another kick SHALL leave kick_cnt at 8'hff.
